hazard_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 13 +
 rtl/md_countdown.sv | 38 +++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline control blocks.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hazard_state_e;

endpackage

// File: rtl/md_countdown.sv
// Down-counter tracking the remaining EX cycles of a multi-cycle mul/div op.
module md_countdown #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Saturate at zero so a stray decrement can never wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and mul/div EX occupancy.
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_md_op,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  ex_redirect,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  md_busy,
    output logic                  md_done
`ifdef HAZARD_CTRL_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_lu_stalls,
    output logic [31:0]           perf_md_stalls,
    output logic [31:0]           perf_flushes
`endif
);

    import mips_pkg::*;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

    hazard_state_e    state_d;
    hazard_state_e    state_q;
    logic             lu;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             lu_stall_cyc;
    logic             redirect_cyc;
    logic             md_wait_cyc;

    md_countdown #(
        .CNT_W (CNT_W)
    ) u_md_countdown (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (MD_LOAD),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    assign lu = id_ex_mem_read
             && (id_ex_rt != REG_ADDR_W'(REG_ZERO))
             && ((id_uses_rs && (id_rs == id_ex_rt)) ||
                 (id_uses_rt && (id_rt == id_ex_rt)));

    // Outputs are forced low while reset is asserted, independent of the flops.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        lu_stall_cyc = 1'b0;
        redirect_cyc = 1'b0;
        md_wait_cyc  = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_write = 1'b1;
                    if (ex_redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        redirect_cyc = 1'b1;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_flush  = 1'b1;
                        lu_stall_cyc = 1'b1;
                    end else if (id_md_op) begin
                        state_d  = MD_WAIT;
                        cnt_load = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy     = 1'b1;
                    cnt_dec     = 1'b1;
                    md_wait_cyc = 1'b1;
                    if (cnt_last) begin
                        md_done     = 1'b1;
                        id_ex_write = 1'b1;
                        state_d     = RUN;
                    end else begin
                        ex_mem_flush = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // EX is occupied by the mul/div, so no redirect or load can legally be in EX now.
    a_md_wait_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == MD_WAIT) |-> (!ex_redirect && !lu && (cnt != '0)));

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_lu_d;
    logic [31:0] perf_lu_q;
    logic [31:0] perf_md_d;
    logic [31:0] perf_md_q;
    logic [31:0] perf_fl_d;
    logic [31:0] perf_fl_q;

    // Saturating event counters; a clear takes precedence over a same-cycle event.
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_md_d = perf_md_q;
        perf_fl_d = perf_fl_q;
        if (perf_clr) begin
            perf_lu_d = '0;
            perf_md_d = '0;
            perf_fl_d = '0;
        end else begin
            if (lu_stall_cyc && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + 32'd1;
            if (md_wait_cyc  && (perf_md_q != '1)) perf_md_d = perf_md_q + 32'd1;
            if (redirect_cyc && (perf_fl_q != '1)) perf_fl_d = perf_fl_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_md_q <= '0;
            perf_fl_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_md_q <= perf_md_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign perf_lu_stalls = perf_lu_q;
    assign perf_md_stalls = perf_md_q;
    assign perf_flushes   = perf_fl_q;
`else
    logic unused_perf;
    assign unused_perf = lu_stall_cyc ^ redirect_cyc ^ md_wait_cyc;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MD_LATENCY = 4.
module tb_hazard_ctrl;

    localparam int RW = 5;

    // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_flush, ex_mem_flush, md_busy, md_done
    localparam logic [7:0] E_RST  = 8'b0000_0000;
    localparam logic [7:0] E_RUN  = 8'b1101_0000;
    localparam logic [7:0] E_LU   = 8'b0001_1000;
    localparam logic [7:0] E_RDR  = 8'b1111_1000;
    localparam logic [7:0] E_MDW  = 8'b0000_0110;
    localparam logic [7:0] E_MDL  = 8'b0001_0011;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] id_rs = '0;
    logic [RW-1:0] id_rt = '0;
    logic          id_uses_rs = 1'b0;
    logic          id_uses_rt = 1'b0;
    logic          id_md_op = 1'b0;
    logic          id_ex_mem_read = 1'b0;
    logic [RW-1:0] id_ex_rt = '0;
    logic          ex_redirect = 1'b0;
    logic          perf_clr = 1'b0;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write;
    logic          id_ex_flush, ex_mem_flush, md_busy, md_done;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0]   perf_lu_stalls, perf_md_stalls, perf_flushes;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_lu = 0;
    int   m_md = 0;
    int   m_fl = 0;

    hazard_ctrl #(
        .REG_ADDR_W (RW),
        .MD_LATENCY (4),
        .CNT_W      (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_md_op       (id_md_op),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .ex_redirect    (ex_redirect),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .md_busy        (md_busy),
        .md_done        (md_done)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_lu_stalls (perf_lu_stalls),
        .perf_md_stalls (perf_md_stalls),
        .perf_flushes   (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and queues the expected outputs.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic urs, input logic urt, input logic md,
                                 input logic mrd, input logic [RW-1:0] ert,
                                 input logic rdr, input logic [7:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rst;
        id_rs          = rs;
        id_rt          = rt;
        id_uses_rs     = urs;
        id_uses_rt     = urt;
        id_md_op       = md;
        id_ex_mem_read = mrd;
        id_ex_rt       = ert;
        ex_redirect    = rdr;
        e.tag = tag;
        e.val = exp;
        sb.push_back(e);
        if (!rst) begin
            m_lu = 0;
            m_md = 0;
            m_fl = 0;
        end else begin
            if (exp == E_LU) m_lu++;
            if (exp[1])      m_md++;
            if (exp[5])      m_fl++;
        end
    endtask

    task automatic idle(input string tag, input logic [7:0] exp);
        applyStimulus(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, exp);
    endtask

    task automatic mdOp(input string tag);
        applyStimulus(tag, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_RUN);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput(e.tag,
                        {24'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                         id_ex_flush, ex_mem_flush, md_busy, md_done},
                        {24'd0, e.val});
        end
    end

    initial begin
        applyStimulus("reset0", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_RST);
        applyStimulus("reset1", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, E_RST);
        idle("run_idle", E_RUN);

        mdOp("rst_md_issue");
        idle("rst_md_w3", E_MDW);
        applyStimulus("rst_mid_op", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_RST);
        idle("rst_release", E_RUN);
        idle("rst_no_done", E_RUN);

        applyStimulus("lu_rs_stall", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, E_LU);
        applyStimulus("lu_rs_after", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, E_RUN);
        applyStimulus("lu_zero_reg", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, E_RUN);
        applyStimulus("lu_rt_stall", 1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, E_LU);
        applyStimulus("lu_rt_after", 1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, E_RUN);
        applyStimulus("lu_unused",   1'b1, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, E_RUN);
        applyStimulus("lu_no_match", 1'b1, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_RUN);
        applyStimulus("lu_md_stall", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, E_LU);
        applyStimulus("lu_md_after", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, E_RUN);

        applyStimulus("rdr_over_lu", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, E_RDR);
        idle("rdr_after", E_RUN);

        mdOp("md_issue");
        idle("md_w3", E_MDW);
        idle("md_w2", E_MDW);
        idle("md_last", E_MDL);
        idle("md_resume", E_RUN);

        mdOp("b2b_issue1");
        idle("b2b1_w3", E_MDW);
        idle("b2b1_w2", E_MDW);
        idle("b2b1_last", E_MDL);
        mdOp("b2b_issue2");
        idle("b2b2_w3", E_MDW);
        idle("b2b2_w2", E_MDW);
        idle("b2b2_last", E_MDL);
        idle("b2b_resume", E_RUN);
        idle("tail", E_RUN);

        repeat (2) @(negedge clk);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

`ifdef HAZARD_CTRL_PERF_EN
        checkOutput("perf_lu", perf_lu_stalls, 32'(m_lu));
        checkOutput("perf_md", perf_md_stalls, 32'(m_md));
        checkOutput("perf_fl", perf_flushes,   32'(m_fl));
        @(posedge clk);
        #1;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        @(negedge clk);
        checkOutput("perf_lu_clr", perf_lu_stalls, 32'd0);
        checkOutput("perf_md_clr", perf_md_stalls, 32'd0);
        checkOutput("perf_fl_clr", perf_flushes,   32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
